// File: rtl/axi_burst_master_if.sv
// AXI3 master/slave bus bundle used by axi_burst_master.
interface axi_burst_master_if #(
    parameter int AW = 32,
    parameter int DW = 64,
    parameter int IW = 4,
    parameter int LW = 4
);
    logic [IW-1:0]   awid;
    logic [AW-1:0]   awaddr;
    logic [LW-1:0]   awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic [1:0]      awlock;
    logic            awvalid;
    logic            awready;

    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wvalid;
    logic            wready;

    logic [IW-1:0]   bid;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready;

    logic [IW-1:0]   arid;
    logic [AW-1:0]   araddr;
    logic [LW-1:0]   arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic [1:0]      arlock;
    logic            arvalid;
    logic            arready;

    logic [IW-1:0]   rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            rvalid;
    logic            rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awcache, awprot, awlock, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awcache, awprot, awlock, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arcache, arprot, arlock, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_burst_master.sv
// Command-driven AXI3 burst master: one read or write burst per command, streaming beats.
// Define AXI_BURST_MASTER_IDCHK_EN to compare bid/rid against the command ID (err_o[0]).
module axi_burst_master #(
    parameter int AW = 32,
    parameter int DW = 64,
    parameter int IW = 4,
    parameter int LW = 4
) (
    input  logic            aclk_i,
    input  logic            arst_i,

    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic            cmd_wr_i,
    input  logic [AW-1:0]   cmd_addr_i,
    input  logic [LW-1:0]   cmd_len_i,
    input  logic [2:0]      cmd_size_i,
    input  logic            cmd_incr_i,
    input  logic [IW-1:0]   cmd_id_i,
    input  logic [2:0]      cmd_prot_i,

    input  logic [DW-1:0]   wd_data_i,
    input  logic [DW/8-1:0] wd_strb_i,
    input  logic            wd_valid_i,
    output logic            wd_ready_o,

    output logic [DW-1:0]   rd_data_o,
    output logic            rd_last_o,
    output logic            rd_valid_o,
    input  logic            rd_ready_i,

    output logic            done_o,
    output logic [1:0]      resp_o,
    output logic [1:0]      err_o,

    axi_burst_master_if.master m_axi
);

    typedef enum logic [2:0] {
        IDLE,
        WR_XFER,
        WR_RESP,
        RD_ADDR,
        RD_DATA
    } state_t;

    state_t        state;
    logic          cmd_ready_q;
    logic          awvalid_q;
    logic          arvalid_q;
    logic          bready_q;
    logic          done_q;
    logic [1:0]    resp_q;
    logic          err_rlast_q;
    logic [LW-1:0] beat_cnt;
    logic          aw_done;
    logic          w_done;

    logic [AW-1:0] addr_q;
    logic [LW-1:0] len_q;
    logic [2:0]    size_q;
    logic          incr_q;
    logic [IW-1:0] id_q;
    logic [2:0]    prot_q;

    logic          w_pending;
    logic          w_beat;
    logic          w_final;
    logic          aw_hs;
    logic          r_active;
    logic          r_beat;
    logic          r_final;
    logic [1:0]    resp_next;

    // Write beats are only exposed while the burst still needs them, so a source
    // that keeps wd_valid_i high cannot leak extra beats onto the bus.
    assign w_pending = (state == WR_XFER) && !w_done;
    assign w_beat    = w_pending && wd_valid_i && m_axi.wready;
    assign w_final   = beat_cnt == len_q;
    assign aw_hs     = awvalid_q && m_axi.awready;
    assign r_active  = state == RD_DATA;
    assign r_beat    = r_active && m_axi.rvalid && rd_ready_i;
    assign r_final   = beat_cnt == len_q;
    assign resp_next = (m_axi.rresp > resp_q) ? m_axi.rresp : resp_q;

`ifdef AXI_BURST_MASTER_IDCHK_EN
    logic err_id_q;

    always_ff @(posedge aclk_i or posedge arst_i) begin
        if (arst_i) begin
            err_id_q <= 1'b0;
        end else if (state == IDLE && cmd_ready_q && cmd_valid_i) begin
            err_id_q <= 1'b0;
        end else if (state == WR_RESP && m_axi.bvalid && m_axi.bid != id_q) begin
            err_id_q <= 1'b1;
        end else if (r_beat && m_axi.rid != id_q) begin
            err_id_q <= 1'b1;
        end
    end

    assign err_o = {err_rlast_q, err_id_q};
`else
    logic unused_id;

    assign unused_id = ^{m_axi.bid, m_axi.rid};
    assign err_o     = {err_rlast_q, 1'b0};
`endif

    always_ff @(posedge aclk_i or posedge arst_i) begin
        if (arst_i) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b0;
            awvalid_q   <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            done_q      <= 1'b0;
            resp_q      <= 2'b00;
            err_rlast_q <= 1'b0;
            beat_cnt    <= '0;
            aw_done     <= 1'b0;
            w_done      <= 1'b0;
            addr_q      <= '0;
            len_q       <= '0;
            size_q      <= 3'h2;
            incr_q      <= 1'b0;
            id_q        <= '0;
            prot_q      <= 3'b000;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (cmd_ready_q && cmd_valid_i) begin
                        cmd_ready_q <= 1'b0;
                        addr_q      <= cmd_addr_i;
                        len_q       <= cmd_len_i;
                        size_q      <= cmd_size_i;
                        incr_q      <= cmd_incr_i;
                        id_q        <= cmd_id_i;
                        prot_q      <= cmd_prot_i;
                        resp_q      <= 2'b00;
                        err_rlast_q <= 1'b0;
                        beat_cnt    <= '0;
                        aw_done     <= 1'b0;
                        w_done      <= 1'b0;
                        if (cmd_wr_i) begin
                            awvalid_q <= 1'b1;
                            state     <= WR_XFER;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_ADDR;
                        end
                    end else begin
                        cmd_ready_q <= 1'b1;
                    end
                end

                // AW and W progress independently; leave once both have finished.
                WR_XFER: begin
                    if (aw_hs) begin
                        awvalid_q <= 1'b0;
                        aw_done   <= 1'b1;
                    end
                    if (w_beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (w_final) begin
                            w_done <= 1'b1;
                        end
                    end
                    if ((aw_done || aw_hs) && (w_done || (w_beat && w_final))) begin
                        bready_q <= 1'b1;
                        state    <= WR_RESP;
                    end
                end

                WR_RESP: begin
                    if (m_axi.bvalid) begin
                        bready_q    <= 1'b0;
                        resp_q      <= m_axi.bresp;
                        done_q      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                        state       <= IDLE;
                    end
                end

                RD_ADDR: begin
                    if (m_axi.arready) begin
                        arvalid_q <= 1'b0;
                        state     <= RD_DATA;
                    end
                end

                // The beat count, not rlast, decides when the burst is over.
                RD_DATA: begin
                    if (r_beat) begin
                        resp_q   <= resp_next;
                        beat_cnt <= beat_cnt + 1'b1;
                        if (m_axi.rlast != r_final) begin
                            err_rlast_q <= 1'b1;
                        end
                        if (r_final) begin
                            done_q      <= 1'b1;
                            cmd_ready_q <= 1'b1;
                            state       <= IDLE;
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = cmd_ready_q;
    assign done_o        = done_q;
    assign resp_o        = resp_q;

    assign m_axi.awid    = id_q;
    assign m_axi.awaddr  = addr_q;
    assign m_axi.awlen   = len_q;
    assign m_axi.awsize  = size_q;
    assign m_axi.awburst = {1'b0, incr_q};
    assign m_axi.awcache = 4'b0000;
    assign m_axi.awprot  = prot_q;
    assign m_axi.awlock  = 2'b00;
    assign m_axi.awvalid = awvalid_q;

    assign m_axi.wvalid  = w_pending && wd_valid_i;
    assign m_axi.wdata   = w_pending ? wd_data_i : '0;
    assign m_axi.wstrb   = w_pending ? wd_strb_i : '0;
    assign m_axi.wlast   = w_pending && w_final;
    assign wd_ready_o    = w_pending && m_axi.wready;

    assign m_axi.bready  = bready_q;

    assign m_axi.arid    = id_q;
    assign m_axi.araddr  = addr_q;
    assign m_axi.arlen   = len_q;
    assign m_axi.arsize  = size_q;
    assign m_axi.arburst = {1'b0, incr_q};
    assign m_axi.arcache = 4'b0000;
    assign m_axi.arprot  = prot_q;
    assign m_axi.arlock  = 2'b00;
    assign m_axi.arvalid = arvalid_q;

    assign m_axi.rready  = r_active && rd_ready_i;
    assign rd_valid_o    = r_active && m_axi.rvalid;
    assign rd_data_o     = r_active ? m_axi.rdata : '0;
    assign rd_last_o     = r_active && m_axi.rlast;

endmodule
